seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU for the calculator datapath; it is the next generation of the 4-bit add/multiply unit.
//  It latches two W-bit unsigned operands and an opcode on a start handshake.
//  It executes clear/add/sub/mul/div and returns a 2W-bit result with a one-cycle done pulse.
//  It sits between the picoVersat register interface and the display/encoder stage.
// PARAMETERS
//  W    4   operand width in bits, legal range 2..16; result width is 2*W
//  CW   $clog2(W)+1   iteration counter width (derived, not overridable)
// PORTS
//  clk        in   1    single clock, all logic on rising edge
//  rst        in   1    synchronous reset, active-low (rst==0 at a rising edge resets)
//  start      in   1    request; accepted only when busy==0
//  first_nr   in   W    operand A (unsigned)
//  second_nr  in   W    operand B (unsigned)
//  operation  in   4    0000 clear, 0001 add, 0010 mul, 0011 sub, 0100 div, others illegal
//  result     out  2W   registered result, held until next accepted op completes
//  busy       out  1    high while an accepted op is executing
//  done       out  1    one-cycle pulse: result/err valid
//  err        out  1    registered with done: 1 = div by zero or illegal opcode
// BEHAVIOUR
//  - Reset (rst==0 at edge): result=0, busy=0, done=0, err=0, FSM->IDLE, counter=0; reset aborts any op in progress.
//  - FSM states:
//    IDLE --start--> EXEC (operands and opcode latched at this edge k; busy=1).
//    EXEC --last iteration--> IDLE (result/err written; done=1 for exactly one cycle; busy=0 at same edge).
//  - Latency L (edges after acceptance edge k until done rises at edge k+L):
//    clear/add/sub/illegal/div-by-zero: L=1
//    mul/div: L=W
//  - start while busy==1 is ignored; operand/opcode inputs are don't-care then.
//  - start in the cycle done==1 (busy==0) is accepted; back-to-back throughput = L+1 cycles.
//  - clear: result=0, err=0.
//  - add: result = zero-extended A+B; carry lands in bit W.
//  - sub: result = A-B as 2W-bit two's complement (sign-extended), e.g. W=4: 3-5 = 8'hFE.
//  - mul: shift-add, one partial product per cycle, LSB of B first; result = A*B unsigned; never errors.
//  - div: restoring, one quotient bit per cycle, MSB first; result[W-1:0]=quotient, result[2W-1:W]=remainder.
//  - div with B==0: no iteration, L=1, result = all ones, err=1.
//  - illegal opcode: L=1, result unchanged, err=1.
//  - err is cleared on the next completed legal op.
//  - done and err are registered outputs; result updates only at the done edge.
//    Intermediate accumulator state never appears on result.
//  - No combinational path from inputs to outputs.
// TESTING (W=4 unless noted)
//  - add 9+7, start 1 cycle -> done 1 edge after accept, result=8'h10, err=0
//  - sub 3-5 -> result=8'hFE at L=1; then clear -> result=8'h00
//  - mul 15*15 -> busy 4 cycles, done at edge k+4, result=8'hE1; pulse start mid-op -> ignored, result unchanged
//  - div 13/4 -> done at k+4, result=8'h13 (rem 1, quo 3); div 9/0 -> L=1, result=8'hFF, err=1
//  - rst=0 during cycle 2 of mul -> next edge: result=0, busy=0, done=0; new add accepted immediately after release
//  - W=8: mul 255*255 -> result=16'hFE01 at k+8; back-to-back add issued on done cycle -> accepted

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: clear/add/sub in one cycle, shift-add multiply and
// restoring divide one bit per cycle, 2W-bit result with a registered done pulse.
module seq_alu #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     first_nr,
    input  logic [W-1:0]     second_nr,
    input  logic [3:0]       operation,
    output logic [2*W-1:0]   result,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(W) + 1;

    localparam logic [3:0] OP_CLR = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_DIV = 4'h4;

    typedef enum logic {IDLE, EXEC} state_e;

    state_e           state_q;
    logic [3:0]       op_q;
    logic [2*W-1:0]   a_q;      // multiplicand / dividend, shifted left each iteration
    logic [W-1:0]     b_q;      // multiplier (shifted right) / divisor (held)
    logic [2*W-1:0]   acc_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     quo_q;
    logic [CW-1:0]    cnt_q;
    logic [2*W-1:0]   result_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [2*W-1:0]   mul_acc_d;
    logic [W:0]       rem_shift;
    logic             div_fits;
    logic [W-1:0]     rem_d;
    logic [W-1:0]     quo_d;
    logic [W:0]       sum;
    logic [W:0]       diff;
    logic             last;
    logic             finish_d;
    logic [2*W-1:0]   result_d;
    logic             err_d;

    // One multiply/divide step plus the completion decision for the current op.
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        mul_acc_d = acc_q + (b_q[0] ? a_q : '0);
        rem_shift = {rem_q, a_q[W-1]};
        div_fits  = rem_shift >= {1'b0, b_q};
        rem_d     = div_fits ? W'(rem_shift - {1'b0, b_q}) : rem_shift[W-1:0];
        quo_d     = {quo_q[W-2:0], div_fits};
        sum       = {1'b0, a_q[W-1:0]} + {1'b0, b_q};
        diff      = {1'b0, a_q[W-1:0]} - {1'b0, b_q};
        last      = (cnt_q == CW'(W - 1));
        finish_d  = 1'b1;
        result_d  = result_q;
        err_d     = 1'b1;
        case (op_q)
            OP_CLR: begin result_d = '0;                             err_d = 1'b0; end
            OP_ADD: begin result_d = {{(W-1){1'b0}}, sum};           err_d = 1'b0; end
            OP_SUB: begin result_d = {{(W-1){diff[W]}}, diff};       err_d = 1'b0; end
            OP_MUL: begin finish_d = last; result_d = mul_acc_d;     err_d = 1'b0; end
            OP_DIV: begin
                if (b_q == '0) begin
                    result_d = '1;
                end else begin
                    finish_d = last;
                    result_d = {rem_d, quo_d};
                    err_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= OP_CLR;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= operation;
                        a_q     <= {{W{1'b0}}, first_nr};
                        b_q     <= second_nr;
                        acc_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    acc_q <= mul_acc_d;
                    a_q   <= a_q << 1;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (op_q == OP_MUL) begin
                        b_q <= b_q >> 1;
                    end
                    if (finish_d) begin
                        result_q <= result_d;
                        err_q    <= err_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
